// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types and constants for the ccff chain loader
//
// Purpose: loader state encoding and byte/remaining-count widths shared by
//          ccff_chain_loader and ccff_byte_serializer.
// Ports:   none (package).
package ccff_loader_pkg;

  localparam int CFG_W = 8;  // configuration bitstream byte width
  localparam int REM_W = 4;  // holds 0..CFG_W unshifted bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } load_state_e;

endpackage

// File: rtl/ccff_byte_serializer.sv
// rtl/ccff_byte_serializer.sv - one-byte parallel-to-serial buffer, MSB first
//
// Purpose: holds one configuration byte plus a count of its unshifted bits.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, empties the buffer
//   flush      in   discard any remaining bits
//   load       in   capture load_data as 8 fresh bits (wins over shift)
//   shift      in   consume the current head bit
//   load_data  in   byte to capture
//   head_bit   out  bit that the next shift consumes
//   not_empty  out  at least one unshifted bit remains
//   last_bit   out  exactly one unshifted bit remains
module ccff_byte_serializer
  import ccff_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             shift,
  input  logic [CFG_W-1:0] load_data,
  output logic             head_bit,
  output logic             not_empty,
  output logic             last_bit
);

  logic [CFG_W-1:0] shreg;
  logic [REM_W-1:0] remaining;

  // A load in the same cycle as the shift of the final bit replaces the
  // buffer outright; that is what lets bytes stream without a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= REM_W'(CFG_W);
    end else if (shift && (remaining != '0)) begin
      shreg     <= {shreg[CFG_W-2:0], 1'b0};
      remaining <= remaining - REM_W'(1);
    end
  end

  assign head_bit  = shreg[CFG_W-1];
  assign not_empty = (remaining != '0);
  assign last_bit  = (remaining == REM_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises a byte bitstream onto the ccff chain head
//
// Purpose: feeds exactly CHAIN_LEN configuration bits, MSB first, into the
//          configuration chain of the logic tiles, then reports done, or err
//          if the byte source stalls for TIMEOUT_CYCLES cycles.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   begins a load from IDLE, DONE or ERR (ignored in LOAD)
//   cfg_data[7:0]  in   bitstream byte, MSB shifted first
//   cfg_valid      in   cfg_data valid
//   cfg_ready      out  loader accepts cfg_data this cycle
//   ccff_head      out  serial bit into the chain head (0 when not shifting)
//   ccff_shift_en  out  chain advances one position this cycle
//   busy           out  loading
//   done           out  load complete
//   err            out  load abandoned on source stall
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN      = 20,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  load_state_e      state;
  load_state_e      state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  idle_cnt;

  logic buf_head;
  logic buf_not_empty;
  logic buf_last;
  logic in_load;
  logic final_shift;
  logic xfer;
  logic idle_tick;
  logic begin_load;
  logic buf_flush;

  always_comb begin
    in_load       = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    final_shift   = 1'b0;
    cfg_ready     = 1'b0;
    xfer          = 1'b0;
    idle_tick     = 1'b0;
    begin_load    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    state_nxt     = state;

    in_load       = (state == LOAD);
    ccff_shift_en = in_load && buf_not_empty && (bit_cnt < LEN);
    ccff_head     = ccff_shift_en && buf_head;
    // The shift that delivers bit CHAIN_LEN-1 ends the load; a byte offered
    // in that cycle would only be flushed, so it is not accepted.
    final_shift   = ccff_shift_en && (bit_cnt == LAST_IDX);
    cfg_ready     = in_load && !final_shift &&
                    (!buf_not_empty || (buf_last && ccff_shift_en));
    xfer          = cfg_valid && cfg_ready;
    idle_tick     = in_load && !buf_not_empty && !cfg_valid;
    begin_load    = start && !in_load;
    busy          = in_load;
    done          = (state == DONE);
    err           = (state == ERR);

    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (final_shift) begin
          state_nxt = DONE;
        end else if (idle_tick && (idle_cnt == TO_LAST)) begin
          state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (begin_load) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        if (ccff_shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
        if (xfer) begin
          idle_cnt <= '0;
        end else if (idle_tick) begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
      end
    end
  end

  // Trailing LSBs of a partial final byte die here at completion.
  assign buf_flush = begin_load || final_shift;

  ccff_byte_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .load      (xfer),
    .shift     (ccff_shift_en),
    .load_data (cfg_data),
    .head_bit  (buf_head),
    .not_empty (buf_not_empty),
    .last_bit  (buf_last)
  );

endmodule
